// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: turns mode/advance/alarm buttons into set levels and advance strobes.
// Optional held-advance auto-repeat: define CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int HOLD    = 2,
    parameter int RPT     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       adv_btn,
    input  logic       alm_btn,
    output logic       timeset,
    output logic       alarmset,
    output logic       minadv,
    output logic       hrsadv,
    output logic       dayadv,
    output logic       datadv,
    output logic       monadv,
    output logic       alarmon,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        RUN   = 4'd0,
        T_MIN = 4'd1,
        T_HRS = 4'd2,
        T_DAY = 4'd3,
        T_DAT = 4'd4,
        T_MON = 4'd5,
        A_MIN = 4'd6,
        A_HRS = 4'd7,
        A_DAY = 4'd8
    } state_e;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("HOLD out of range");
    end
    if (RPT < 1 || RPT > 255) begin : g_bad_rpt
        $error("RPT out of range");
    end

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0] btn_raw;
    logic [2:0] s1_q;
    logic [2:0] s2_q;
    logic [2:0] s3_q;
    logic [2:0] s3_d;
    logic [1:0] warm_q;
    logic       mode_p;
    logic       adv_p;
    logic       alm_p;
    logic       any_p;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] idle_q;
    logic [7:0] idle_d;
    logic       alarmon_q;
    logic       alarmon_d;
    logic       ts_q;
    logic       ts_d;
    logic       as_q;
    logic       as_d;
    logic [4:0] stb_q;
    logic [4:0] stb_d;
    logic       active;
    logic       adv_go;
    logic       rep_go;

    assign btn_raw = {alm_btn, adv_btn, mode_btn};

    // sync3 is held at 1 until two sync cycles elapse, so a held button is no press
    assign s3_d   = (warm_q == 2'd2) ? s2_q : s3_q;
    assign mode_p = s2_q[0] & ~s3_q[0];
    assign adv_p  = s2_q[1] & ~s3_q[1];
    assign alm_p  = s2_q[2] & ~s3_q[2];
    assign any_p  = mode_p | adv_p | alm_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '1;
            warm_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
            s3_q <= s3_d;
            if (warm_q != 2'd2) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign active = (state_q != RUN) && (state_q <= A_DAY);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam logic [7:0] HOLD8 = 8'(HOLD);
    localparam logic [7:0] RPT8  = 8'(RPT);

    logic [7:0] rpt_q;
    logic [7:0] rpt_d;
    logic       rfirst_q;
    logic       rfirst_d;

    always_comb begin
        rpt_d    = '0;
        rfirst_d = 1'b1;
        rep_go   = 1'b0;
        if (active && s2_q[1] && !mode_p) begin
            if (adv_p) begin
                rpt_d = 8'd1;
            end else if (rpt_q != 8'd0) begin
                if (rpt_q == (rfirst_q ? HOLD8 : RPT8)) begin
                    rep_go   = 1'b1;
                    rpt_d    = 8'd1;
                    rfirst_d = 1'b0;
                end else begin
                    rpt_d    = rpt_q + 8'd1;
                    rfirst_d = rfirst_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_q    <= '0;
            rfirst_q <= 1'b1;
        end else begin
            rpt_q    <= rpt_d;
            rfirst_q <= rfirst_d;
        end
    end
`else
    assign rep_go = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        alarmon_d = alarmon_q ^ alm_p;
        stb_d     = '0;
        adv_go    = active && ((adv_p && !mode_p) || rep_go);

        if (mode_p) begin
            unique case (state_q)
                RUN:     state_d = T_MIN;
                T_MIN:   state_d = T_HRS;
                T_HRS:   state_d = T_DAY;
                T_DAY:   state_d = T_DAT;
                T_DAT:   state_d = T_MON;
                T_MON:   state_d = A_MIN;
                A_MIN:   state_d = A_HRS;
                A_HRS:   state_d = A_DAY;
                default: state_d = RUN;
            endcase
        end else if (!active) begin
            state_d = RUN;
        end else if (!any_p && idle_q == TO_LAST) begin
            state_d = RUN;
        end

        if (state_d == RUN || any_p || rep_go) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 8'd1;
        end

        if (adv_go) begin
            unique case (state_q)
                T_MIN, A_MIN: stb_d = 5'b10000;
                T_HRS, A_HRS: stb_d = 5'b01000;
                T_DAY, A_DAY: stb_d = 5'b00100;
                T_DAT:        stb_d = 5'b00010;
                T_MON:        stb_d = 5'b00001;
                default:      stb_d = 5'b00000;
            endcase
        end

        ts_d = (state_d >= T_MIN) && (state_d <= T_MON);
        as_d = (state_d >= A_MIN) && (state_d <= A_DAY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            idle_q    <= '0;
            alarmon_q <= 1'b0;
            ts_q      <= 1'b0;
            as_q      <= 1'b0;
            stb_q     <= '0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            alarmon_q <= alarmon_d;
            ts_q      <= ts_d;
            as_q      <= as_d;
            stb_q     <= stb_d;
        end
    end

    assign timeset  = ts_q;
    assign alarmset = as_q;
    assign minadv   = stb_q[4];
    assign hrsadv   = stb_q[3];
    assign dayadv   = stb_q[2];
    assign datadv   = stb_q[1];
    assign monadv   = stb_q[0];
    assign alarmon  = alarmon_q;
    assign state    = state_q;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Button-sequencing controller for the digital alarm clock datapath; it replaces direct wiring of the manual buttons.
- Converts three raw push-buttons (mode, advance, alarm) into the level and strobe controls the time/alarm counter bank consumes: timeset, alarmset, minadv, hrsadv, dayadv, datadv, monadv, alarmon.
- Walks a field-select state machine, issues exactly one advance strobe per press, and falls back to run mode after inactivity.
- Clocked by the same 1-cycle/sec pulse as the counters.

Parameters:
- TIMEOUT, 30, idle cycles in any set state before automatic return to RUN; legal range 2..255.
- HOLD, 2, cycles advance must stay held after its press edge before the first auto-repeat strobe (AUTO_REPEAT_EN only); range 1..255.
- RPT, 1, cycles between subsequent auto-repeat strobes (AUTO_REPEAT_EN only); range 1..255.

Ports:
- clk  input  1  clock (the system pulse)
- rst  input  1  reset, asynchronous, active-low
- mode_btn  input  1  raw mode button, asynchronous level
- adv_btn  input  1  raw advance button, asynchronous level
- alm_btn  input  1  raw alarm-enable toggle button, asynchronous level
- timeset  output  1  high in all T_* states
- alarmset  output  1  high in all A_* states
- minadv  output  1  one-cycle strobe in T_MIN/A_MIN
- hrsadv  output  1  one-cycle strobe in T_HRS/A_HRS
- dayadv  output  1  one-cycle strobe in T_DAY/A_DAY
- datadv  output  1  one-cycle strobe in T_DAT
- monadv  output  1  one-cycle strobe in T_MON
- alarmon  output  1  alarm enable level
- state  output  4  current state encoding, for display blinking

Behaviour:
- Input conditioning
  - Each button passes through a 2-flop synchronizer, then rising-edge detect (sync2 & ~sync3).
  - A button rising before clk edge k yields a detected press at edge k+2.
  - All effects (state change, strobe, toggle) are registered at edge k+2 and visible during cycle k+2..k+3.
- States and encoding: RUN=0, T_MIN=1, T_HRS=2, T_DAY=3, T_DAT=4, T_MON=5, A_MIN=6, A_HRS=7, A_DAY=8; codes 9..15 are illegal.
- Mode press advances state:
  - RUN→T_MIN→T_HRS→T_DAY→T_DAT→T_MON→A_MIN→A_HRS→A_DAY→RUN.
  - An illegal code goes to RUN on the next edge.
- Advance press in a non-RUN state pulses the matching *adv output high for exactly one cycle. Advance presses in RUN are ignored.
- Mode press and advance press detected on the same edge: mode wins, the advance is discarded, no strobe.
- Alarm press toggles alarmon in any state, independent of mode and advance. This includes the same edge as a mode or advance press.
- All outputs are registered. timeset and alarmset are decoded from the next-state value, so they are never both high, and the *adv strobes are mutually exclusive.
- Idle counter (8-bit)
  - Cleared on entry to any non-RUN state and on any detected press (mode, adv or alm).
  - Increments each cycle while in a non-RUN state and no press is detected.
  - When the count reaches TIMEOUT-1 with no press on that edge, the next state is RUN and the counter clears.
  - A press on that same edge takes priority and restarts the count.
  - Held at 0 in RUN.
- Holding mode or advance high produces no further edges (AUTO_REPEAT_EN aside); release and re-press is required.
- Reset (rst low, asynchronous)
  - state=RUN; timeset, alarmset, every *adv output and alarmon = 0.
  - Synchronizer flops, idle counter and repeat counter = 0.
  - Reset mid-strobe terminates the strobe immediately.
  - A button already held at reset release is not seen as a press, because the edge detector starts with sync3 = 0 only after two cycles of sync. sync3 resets to 1 for all buttons to enforce this.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- Defined:
  - While synchronized adv stays high in a non-RUN state, an 8-bit repeat counter runs from the press edge.
  - The first extra strobe occurs HOLD cycles after the press strobe, then one every RPT cycles until release.
  - Repeat strobes reset the idle counter.
  - A mode press or release clears the repeat counter.
- Undefined: one strobe per press only; the repeat counter logic is absent.

Test Plan:
- Reset release with all buttons low → state=0, all outputs 0. Hold adv_btn high through reset release, adv stays held → no strobe ever.
- Mode pressed 1 cycle, 9 times with gaps → state sequence 1,2,3,4,5,6,7,8,0. timeset high for states 1-5, alarmset high for 6-8, never both.
- In state 4 (T_DAT), adv pressed 3 times → datadv high for exactly 3 single cycles, each 2 edges after the press. No other *adv toggles.
- Mode and adv rise in the same cycle while in T_MIN → state becomes 2, minadv and hrsadv stay 0. alm_btn pressed alongside → alarmon toggles 0→1.
- TIMEOUT=30: enter T_HRS, no presses → state returns to 0 exactly 30 cycles after entry. A press at cycle 29 restarts the count, giving RUN 30 cycles after that press.
- With CLOCK_SET_AUTO_REPEAT_EN, HOLD=2, RPT=1, adv held 6 cycles in T_MIN → minadv strobes at press+0, +2, +3, +4, +5, then none after release. Without the macro → single strobe.
